// File: rtl/rc5_pkg.sv
// rtl/rc5_pkg.sv - shared RC5 constants and key-expansion state type
package rc5_pkg;

   localparam int W        = 32;
   localparam int R        = 12;
   localparam int T        = 2 * (R + 1);
   localparam int T_LENGTH = $clog2(T);

   localparam logic [W-1:0] P32 = 32'hB7E15163;
   localparam logic [W-1:0] Q32 = 32'h9E3779B9;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_t;

endpackage

// File: rtl/rc5_s_array_init_if.sv
// rtl/rc5_s_array_init_if.sv - S memory write port between the initialiser and the array owner
interface rc5_s_array_init_if
   import rc5_pkg::*;
#(
   parameter int w        = W,
   parameter int t_length = T_LENGTH
);

   logic [w-1:0]        S_sub_i;
   logic [w-1:0]        S_sub_i_prima;
   logic [t_length-1:0] S_address;
   logic                S_we;
   logic                done;

   // master is the initialiser, slave is the memory owner
   modport master (
      input  S_sub_i,
      output S_sub_i_prima,
      output S_address,
      output S_we,
      output done
   );

   modport slave (
      output S_sub_i,
      input  S_sub_i_prima,
      input  S_address,
      input  S_we,
      input  done
   );

endinterface

// File: rtl/rc5_addr_counter.sv
// rtl/rc5_addr_counter.sv - saturating up-counter from start to t-1 with terminal-count flag
module rc5_addr_counter
   import rc5_pkg::*;
#(
   parameter int t        = T,
   parameter int t_length = T_LENGTH,
   parameter int start    = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   output logic [t_length-1:0] count,
   output logic                tc
);

   localparam logic [t_length-1:0] FIRST = t_length'(start);
   localparam logic [t_length-1:0] LAST  = t_length'(t - 1);

   // saturation on tc keeps the count inside 0..t-1 when t is not a power of two
   assign tc = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= FIRST;
      end else if (en && !tc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/rc5_s_array_init.sv
// rtl/rc5_s_array_init.sv - fills RC5 S array with the Pw/Qw progression; RC5_S_SEED_EN also writes S[0]
module rc5_s_array_init
   import rc5_pkg::*;
#(
   parameter int           w        = W,
   parameter int           t        = T,
   parameter int           t_length = T_LENGTH,
   parameter logic [w-1:0] qW       = Q32,
   parameter logic [w-1:0] pW       = P32
) (
   input  logic              clk1,
   input  logic              rst,
   rc5_s_array_init_if.master s_if
);

`ifdef RC5_S_SEED_EN
   localparam int ADDR_START = 0;
`else
   localparam int ADDR_START = 1;
`endif

   state_t              state;
   state_t              state_next;
   logic                s_we;
   logic                s_we_next;
   logic                done_r;
   logic                done_next;
   logic                cnt_en;
   logic                last_addr;
   logic [t_length-1:0] addr;

   rc5_addr_counter #(
      .t        (t),
      .t_length (t_length),
      .start    (ADDR_START)
   ) u_addr_counter (
      .clk   (clk1),
      .rst_n (rst),
      .en    (cnt_en),
      .count (addr),
      .tc    (last_addr)
   );

   // the address only moves on edges that actually perform a write
   assign cnt_en = s_we && (state == RUN);

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         state  <= RUN;
         s_we   <= 1'b0;
         done_r <= 1'b0;
      end else begin
         state  <= state_next;
         s_we   <= s_we_next;
         done_r <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (s_we && last_addr) state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = RUN;
      endcase
      s_we_next = (state_next == RUN);
      done_next = (state_next == DONE);
   end

`ifdef RC5_S_SEED_EN
   assign s_if.S_sub_i_prima = (addr == '0) ? pW : s_if.S_sub_i + qW;
`else
   // pW only matters when the block seeds S[0] itself
   logic [w-1:0] unused_pw;
   assign unused_pw          = pW;
   assign s_if.S_sub_i_prima = s_if.S_sub_i + qW;
`endif

   assign s_if.S_address = addr;
   assign s_if.S_we      = s_we;
   assign s_if.done      = done_r;

endmodule

// File: tb/tb_rc5_s_array_init.sv
// tb/tb_rc5_s_array_init.sv - self-checking bench for rc5_s_array_init
module tb_rc5_s_array_init;

`ifdef RC5_S_SEED_EN
   localparam int START = 0;
`else
   localparam int START = 1;
`endif
   localparam int NT = 26;
   localparam int NW = NT - START;

   typedef struct {
      logic [31:0] s_sub_i;
      logic [31:0] s_sub_i_prima;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk1 = 1'b0;
   logic        rst  = 1'b0;
   logic [31:0] mem [0:31];
   logic [31:0] wrap_in;
   wr_t         exp_q [$];
   int          n_vec  = 0;
   int          n_miss = 0;
   int          nwrites = 0;
   vec_t        vecs [4];

   always #5 clk1 = ~clk1;

   rc5_s_array_init_if #(.w(32), .t_length(5)) sif ();
   rc5_s_array_init_if #(.w(32), .t_length(5)) wif ();

   rc5_s_array_init #(
      .w(32), .t(NT), .t_length(5), .qW(32'd5), .pW(32'd10)
   ) dut (
      .clk1 (clk1),
      .rst  (rst),
      .s_if (sif)
   );

   rc5_s_array_init #(
      .w(32), .t(NT), .t_length(5), .qW(32'h9E3779B9), .pW(32'hB7E15163)
   ) dut_wrap (
      .clk1 (clk1),
      .rst  (1'b0),
      .s_if (wif)
   );

   assign sif.S_sub_i = (sif.S_address == 5'd0) ? 32'd0 : mem[sif.S_address - 5'd1];
   assign wif.S_sub_i = wrap_in;

   always @(posedge clk1) begin
      if (sif.S_we) mem[sif.S_address] <= sif.S_sub_i_prima;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every observed write must match the next expected (address, data)
   always @(negedge clk1) begin
      if (sif.S_we === 1'b1) begin
         nwrites++;
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", 32'(sif.S_address), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", 32'(sif.S_address), 32'(e.addr));
            check("write_data", sif.S_sub_i_prima, e.data);
         end
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_addr"}, 32'(sif.S_address), START);
      check({tag, "_done"}, 32'(sif.done), 0);
      check({tag, "_we"},   32'(sif.S_we), 0);
   endtask

   task automatic arm_run();
      exp_q.delete();
      nwrites = 0;
      for (int i = START; i < NT; i++) begin
         wr_t e;
         e.addr = 5'(i);
         e.data = 32'(10 + 5 * i);
         exp_q.push_back(e);
      end
   endtask

   task automatic release_and_finish(input string tag);
      logic       prev_we;
      logic [4:0] prev_addr;
      int         budget;
      prev_we   = 1'b0;
      prev_addr = '0;
      budget    = 0;
      @(negedge clk1);
      rst = 1'b1;
      @(negedge clk1);
      check({tag, "_first_we"},   32'(sif.S_we), 1);
      check({tag, "_first_addr"}, 32'(sif.S_address), START);
      while (sif.done !== 1'b1 && budget < 60) begin
         prev_we   = sif.S_we;
         prev_addr = sif.S_address;
         @(negedge clk1);
         budget++;
      end
      check({tag, "_done_reached"},   32'(sif.done), 1);
      check({tag, "_done_last_we"},   32'(prev_we), 1);
      check({tag, "_done_last_addr"}, 32'(prev_addr), NT - 1);
      check({tag, "_we_after_done"},  32'(sif.S_we), 0);
      check({tag, "_write_count"},    32'(nwrites), NW);
      check({tag, "_queue_empty"},    32'(exp_q.size()), 0);
      for (int i = 0; i < 32; i++)
         check({tag, "_mem"}, mem[i], (i < NT) ? 32'(10 + 5 * i) : 32'd0);
   endtask

   initial begin
      vecs[0] = '{32'hB7E15163, 32'h5618CB1C};
      vecs[1] = '{32'h00000000, 32'h9E3779B9};
      vecs[2] = '{32'hFFFFFFFF, 32'h9E3779B8};
      vecs[3] = '{32'h61C88647, 32'h00000000};

      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      mem[0]  = 32'd10;
      wrap_in = 32'd0;

      repeat (3) @(negedge clk1);
      check_reset_values("reset");

      for (int i = 0; i < 4; i++) begin
         wrap_in = vecs[i].s_sub_i;
         #1;
         check("wrap_add", wif.S_sub_i_prima, vecs[i].s_sub_i_prima);
      end

      arm_run();
      release_and_finish("run1");

      // restart from reset, then interrupt the run asynchronously at address 10
      @(negedge clk1);
      rst = 1'b0;
      for (int i = 1; i < 32; i++) mem[i] = 32'd0;
      arm_run();
      @(negedge clk1);
      rst = 1'b1;
      for (int i = 0; i < 40 && sif.S_address !== 5'd10; i++) @(negedge clk1);
      check("reached_addr10", 32'(sif.S_address), 10);
      #2 rst = 1'b0;
      #1 check_reset_values("midrun_reset");
      check("midrun_mem10_unwritten", mem[10], 32'd0);

      @(negedge clk1);
      for (int i = 1; i < 32; i++) mem[i] = 32'd0;
      arm_run();
      release_and_finish("rerun");

      for (int i = 0; i < 40; i++) begin
         @(negedge clk1);
         check("hold_we",   32'(sif.S_we), 0);
         check("hold_addr", 32'(sif.S_address), NT - 1);
         check("hold_done", 32'(sif.done), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
